// File: rtl/watch_pkg.sv
// Shared encodings and default timing for the watch time-setting controller.
package watch_pkg;

    localparam logic [1:0] MODE_RUN       = 2'd0;
    localparam logic [1:0] MODE_SET_SECS  = 2'd1;
    localparam logic [1:0] MODE_SET_MINS  = 2'd2;
    localparam logic [1:0] MODE_SET_HOURS = 2'd3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 200;
    localparam int DEFAULT_REPEAT_DELAY    = 5000;
    localparam int DEFAULT_REPEAT_PERIOD   = 2000;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 300000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronizes a raw push-button, debounces it and emits a one-cycle press pulse
// on each accepted 0->1 transition.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    // The level only follows the synchronized input after it has disagreed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            level      <= 1'b0;
            press      <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_1 <= btn_in;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 != level) begin
                if (stable_cnt >= CNT_LAST) begin
                    level      <= sync_2;
                    press      <= sync_2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/watch_set_controller.sv
// Sequences RUN/SET_SECS/SET_MINS/SET_HOURS from conditioned MODE/ADJUST buttons,
// issues increment pulses with auto-repeat, and gates the 1 Hz advance tick.
module watch_set_controller
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode_in,
    input  logic       btn_adj_in,
    input  logic       tick_1hz_in,
    output logic [1:0] mode,
    output logic       inc_secs,
    output logic       inc_mins,
    output logic       inc_hours,
    output logic       sec_tick
);

    localparam int RCW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RCW-1:0] DELAY_LAST   = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PERIOD_LAST  = RCW'(REPEAT_PERIOD - 1);
    localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

    logic           mode_press;
    logic           unused_mode_level;
    logic           adj_press;
    logic           adj_level;
    logic [1:0]     state;
    logic           repeat_active;
    logic           repeat_first;
    logic [RCW-1:0] repeat_cnt;
    logic [TCW-1:0] timeout_cnt;
    logic           tick_1;
    logic           tick_2;
    logic           tick_3;
    logic           in_set;
    logic           timeout_hit;
    logic           fire;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_mode_in),
        .level  (unused_mode_level),
        .press  (mode_press)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adj_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_adj_in),
        .level  (adj_level),
        .press  (adj_press)
    );

    // Priority: MODE press, then ADJUST press, then timeout, then auto-repeat.
    always_comb begin
        in_set      = (state != MODE_RUN);
        timeout_hit = in_set && (timeout_cnt == TIMEOUT_LAST);
        fire        = 1'b0;
        if (!mode_press && in_set) begin
            if (adj_press) begin
                fire = 1'b1;
            end else if (!timeout_hit && repeat_active && adj_level) begin
                fire = (repeat_cnt == (repeat_first ? DELAY_LAST : PERIOD_LAST));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= MODE_RUN;
            repeat_active <= 1'b0;
            repeat_first  <= 1'b0;
            repeat_cnt    <= '0;
            timeout_cnt   <= '0;
            inc_secs      <= 1'b0;
            inc_mins      <= 1'b0;
            inc_hours     <= 1'b0;
        end else begin
            inc_secs  <= fire && (state == MODE_SET_SECS);
            inc_mins  <= fire && (state == MODE_SET_MINS);
            inc_hours <= fire && (state == MODE_SET_HOURS);
            if (mode_press) begin
                state         <= state + 2'd1;
                timeout_cnt   <= '0;
                repeat_active <= 1'b0;
            end else if (adj_press && in_set) begin
                repeat_active <= 1'b1;
                repeat_first  <= 1'b1;
                repeat_cnt    <= '0;
                timeout_cnt   <= '0;
            end else if (timeout_hit) begin
                state         <= MODE_RUN;
                timeout_cnt   <= '0;
                repeat_active <= 1'b0;
            end else begin
                timeout_cnt <= in_set ? timeout_cnt + 1'b1 : '0;
                if (repeat_active && adj_level && in_set) begin
                    if (fire) begin
                        repeat_cnt   <= '0;
                        repeat_first <= 1'b0;
                    end else begin
                        repeat_cnt <= repeat_cnt + 1'b1;
                    end
                end else begin
                    repeat_active <= 1'b0;
                end
            end
        end
    end

    // Ticks arriving while seconds are being set are dropped, not held over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_1   <= 1'b0;
            tick_2   <= 1'b0;
            tick_3   <= 1'b0;
            sec_tick <= 1'b0;
        end else begin
            tick_1   <= tick_1hz_in;
            tick_2   <= tick_1;
            tick_3   <= tick_2;
            sec_tick <= tick_2 && !tick_3 && (state != MODE_SET_SECS);
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_watch_set_controller.sv
// Scoreboard bench for watch_set_controller: stimulus queues expected output
// events with their cycle; a negedge monitor pops and compares them.
module tb_watch_set_controller;

    localparam int DEB  = 4;
    localparam int RDEL = 20;
    localparam int RPER = 5;
    localparam int TOUT = 100;
    localparam int LAT  = 7;

    localparam int EV_MODE  = 0;
    localparam int EV_SECS  = 1;
    localparam int EV_MINS  = 2;
    localparam int EV_HOURS = 3;
    localparam int EV_TICK  = 4;

    typedef struct {
        int kind;
        int value;
        int cycle;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode_in = 1'b0;
    logic       btn_adj_in = 1'b0;
    logic       tick_1hz_in = 1'b0;
    logic [1:0] mode;
    logic       inc_secs;
    logic       inc_mins;
    logic       inc_hours;
    logic       sec_tick;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       monitor_en = 1'b0;
    logic [1:0] prev_mode = 2'd0;
    ev_t        expq[$];

    watch_set_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDEL),
        .REPEAT_PERIOD  (RPER),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode_in(btn_mode_in),
        .btn_adj_in (btn_adj_in),
        .tick_1hz_in(tick_1hz_in),
        .mode       (mode),
        .inc_secs   (inc_secs),
        .inc_mins   (inc_mins),
        .inc_hours  (inc_hours),
        .sec_tick   (sec_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expectEvent(input int kind, input int value, input int cycle);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        e.cycle = cycle;
        expq.push_back(e);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic m, input logic a, input int hold);
        int start;
        start = cyc;
        if (m) btn_mode_in = 1'b1;
        if (a) btn_adj_in = 1'b1;
        waitUntil(start + hold);
        if (m) btn_mode_in = 1'b0;
        if (a) btn_adj_in = 1'b0;
    endtask

    task automatic checkOutput(input int kind, input int value, input string name);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: got event value %0d at cycle %0d, expected no event", name, value, cyc);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.value != value || e.cycle != cyc) begin
                errors++;
                $display("[TB] FAIL %s: got kind %0d value %0d at cycle %0d, expected kind %0d value %0d at cycle %0d",
                         name, kind, value, cyc, e.kind, e.value, e.cycle);
            end
        end
    endtask

    task automatic checkLevel(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkLevel({tag, "_mode"}, int'(mode), 0);
        checkLevel({tag, "_inc_secs"}, int'(inc_secs), 0);
        checkLevel({tag, "_inc_mins"}, int'(inc_mins), 0);
        checkLevel({tag, "_inc_hours"}, int'(inc_hours), 0);
        checkLevel({tag, "_sec_tick"}, int'(sec_tick), 0);
    endtask

    always @(negedge clk) begin
        if (monitor_en) begin
            if (mode !== prev_mode) checkOutput(EV_MODE, int'(mode), "mode");
            if (inc_secs)  checkOutput(EV_SECS, 1, "inc_secs");
            if (inc_mins)  checkOutput(EV_MINS, 1, "inc_mins");
            if (inc_hours) checkOutput(EV_HOURS, 1, "inc_hours");
            if (sec_tick)  checkOutput(EV_TICK, 1, "sec_tick");
            prev_mode <= mode;
        end
    end

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;
        monitor_en = 1'b1;
        waitUntil(cyc + 5);

        $display("[TB] four clean MODE presses");
        for (int v = 1; v <= 4; v++) begin
            c = cyc;
            expectEvent(EV_MODE, v % 4, c + LAT);
            applyStimulus(1'b1, 1'b0, 10);
            waitUntil(c + 30);
        end

        $display("[TB] bouncing MODE press");
        c = cyc;
        expectEvent(EV_MODE, 1, c + 8 + LAT);
        btn_mode_in = 1'b1;
        waitUntil(c + 2);  btn_mode_in = 1'b0;
        waitUntil(c + 4);  btn_mode_in = 1'b1;
        waitUntil(c + 6);  btn_mode_in = 1'b0;
        waitUntil(c + 8);  btn_mode_in = 1'b1;
        waitUntil(c + 18); btn_mode_in = 1'b0;
        waitUntil(c + 38);
        c = cyc;
        expectEvent(EV_MODE, 2, c + LAT);
        applyStimulus(1'b1, 1'b0, 10);
        waitUntil(c + 30);

        $display("[TB] ADJUST auto-repeat in SET_MINS then timeout");
        c = cyc;
        expectEvent(EV_MINS, 1, c + LAT);
        expectEvent(EV_MINS, 1, c + LAT + RDEL);
        expectEvent(EV_MINS, 1, c + LAT + RDEL + RPER);
        expectEvent(EV_MINS, 1, c + LAT + RDEL + 2 * RPER);
        expectEvent(EV_MINS, 1, c + LAT + RDEL + 3 * RPER);
        expectEvent(EV_MODE, 0, c + LAT + TOUT);
        applyStimulus(1'b0, 1'b1, 40);
        waitUntil(c + 115);

        $display("[TB] ADJUST in RUN, then MODE+ADJUST together in SET_HOURS");
        c = cyc;
        applyStimulus(1'b0, 1'b1, 10);
        waitUntil(c + 30);
        for (int v = 1; v <= 3; v++) begin
            c = cyc;
            expectEvent(EV_MODE, v, c + LAT);
            applyStimulus(1'b1, 1'b0, 10);
            waitUntil(c + 30);
        end
        c = cyc;
        expectEvent(EV_MODE, 0, c + LAT);
        applyStimulus(1'b1, 1'b1, 10);
        waitUntil(c + 30);

        $display("[TB] SET_SECS timeout and tick gating");
        c = cyc;
        expectEvent(EV_MODE, 1, c + LAT);
        expectEvent(EV_MODE, 0, c + LAT + TOUT);
        expectEvent(EV_TICK, 1, c + 123);
        applyStimulus(1'b1, 1'b0, 10);
        waitUntil(c + 30);  tick_1hz_in = 1'b1;
        waitUntil(c + 40);  tick_1hz_in = 1'b0;
        waitUntil(c + 60);  tick_1hz_in = 1'b1;
        waitUntil(c + 70);  tick_1hz_in = 1'b0;
        waitUntil(c + 120); tick_1hz_in = 1'b1;
        waitUntil(c + 130); tick_1hz_in = 1'b0;
        waitUntil(c + 140);

        $display("[TB] reset during auto-repeat in SET_SECS");
        c = cyc;
        expectEvent(EV_MODE, 1, c + LAT);
        expectEvent(EV_SECS, 1, c + 30 + LAT);
        expectEvent(EV_SECS, 1, c + 30 + LAT + RDEL);
        expectEvent(EV_MODE, 0, c + 60);
        expectEvent(EV_MODE, 1, c + 80 + LAT);
        expectEvent(EV_SECS, 1, c + 115 + LAT);
        expectEvent(EV_MODE, 0, c + 115 + LAT + TOUT);
        applyStimulus(1'b1, 1'b0, 10);
        waitUntil(c + 30);  btn_adj_in = 1'b1;
        waitUntil(c + 60);
        reset = 1'b1;
        #1;
        checkAllZero("midreset");
        waitUntil(c + 63);  reset = 1'b0;
        waitUntil(c + 80);  btn_mode_in = 1'b1;
        waitUntil(c + 90);  btn_mode_in = 1'b0;
        waitUntil(c + 100); btn_adj_in = 1'b0;
        waitUntil(c + 115); btn_adj_in = 1'b1;
        waitUntil(c + 125); btn_adj_in = 1'b0;
        waitUntil(c + 240);

        monitor_en = 1'b0;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            foreach (expq[i])
                $display("[TB] FAIL missing_event: got nothing, expected kind %0d value %0d at cycle %0d",
                         expq[i].kind, expq[i].value, expq[i].cycle);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/watch_set_controller.md
Name: watch_set_controller

Overview:
- Synchronous controller that sequences time-setting of the homegrown watch datapath.
- Conditions the raw MODE and ADJUST push-buttons, then steps through RUN / SET_SECS / SET_MINS / SET_HOURS.
- Issues single-cycle increment pulses to the seconds/minutes/hours shift registers, and gates the 1 Hz advance tick while seconds are being set.
- Replaces the asynchronous mode counter and increment demux. Its mode output feeds the mode LED processor.

Parameters:
- DEBOUNCE_CYCLES, default 200: consecutive stable clk cycles needed to accept a button level change.
- REPEAT_DELAY, default 5000: clk cycles ADJUST must be held before auto-repeat starts.
- REPEAT_PERIOD, default 2000: clk cycles between auto-repeat pulses.
- TIMEOUT_CYCLES, default 300000: clk cycles without any accepted press before a SET state returns to RUN.

Ports:
- clk  input  1  system clock; tick_1hz_in is slow relative to it.
- reset  input  1  asynchronous, active-high.
- btn_mode_in  input  1  raw MODE button, active-high, asynchronous.
- btn_adj_in  input  1  raw ADJUST button, active-high, asynchronous.
- tick_1hz_in  input  1  1 Hz square wave from clock stepdown, asynchronous to clk.
- mode  output  2  0=RUN, 1=SET_SECS, 2=SET_MINS, 3=SET_HOURS.
- inc_secs  output  1  one-cycle increment pulse to the seconds register.
- inc_mins  output  1  one-cycle increment pulse to the minutes register.
- inc_hours  output  1  one-cycle increment pulse to the hours register.
- sec_tick  output  1  one-cycle pulse per 1 Hz rising edge, gated.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- On reset: state RUN, mode=0, all inc_* = 0, sec_tick = 0, debounced levels 0, all counters 0.
- Every async input passes through a 2-FF synchronizer.
- Debounce: the debounced level updates only when the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- A press event is a 1-cycle pulse on the debounced 0->1 transition. Releases generate no event.
- FSM transitions on MODE press: RUN->SET_SECS->SET_MINS->SET_HOURS->RUN.
- mode is registered and changes the cycle after the MODE press event.
- ADJUST press in a SET state: the matching inc_* is high for exactly one cycle, the cycle after the press event.
- ADJUST press in RUN: ignored, no pulse.
- Auto-repeat while ADJUST stays debounced-high in a SET state:
  - first repeat pulse REPEAT_DELAY cycles after the initial pulse;
  - further pulses every REPEAT_PERIOD cycles;
  - stops on debounced release.
- At most one inc_* is high in any cycle. inc_* are never high in RUN.
- MODE and ADJUST press events in the same cycle: MODE wins, state advances, no inc pulse.
- MODE press while ADJUST is held: repeat stops. A new ADJUST press (release then press) is required before further increments.
- Timeout: in any SET state, TIMEOUT_CYCLES cycles with no MODE/ADJUST press event forces RUN.
  - Auto-repeat pulses do not reset the timeout counter.
  - The timeout counter clears on each press event and on entry to a SET state.
  - Timeout and a press event in the same cycle: the press event wins.
- sec_tick: 1-cycle pulse on each synchronized rising edge of tick_1hz_in.
  - Latency is 3 clk cycles from the input edge (2 sync + edge register).
  - Suppressed while state is SET_SECS; a suppressed tick is dropped, not deferred.
- Counters saturate or clear as specified; none wrap. Counter widths are $clog2(param+1).
- Reset asserted mid-hold or mid-debounce aborts everything to reset values. No pulse is emitted on reset release.

Decomposition:
- Shared package watch_pkg:
  - mode/state encoding constants MODE_RUN=0, MODE_SET_SECS=1, MODE_SET_MINS=2, MODE_SET_HOURS=3;
  - default timing constants.
- Sub-module button_conditioner (synchronizer + debouncer + rising-edge press pulse, parameter DEBOUNCE_CYCLES), instantiated twice.
- FSM, repeat timer, timeout timer and tick gating live in watch_set_controller.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, TIMEOUT_CYCLES=100.
- Reset then 4 clean MODE presses, each held 10 cycles -> mode sequence 1,2,3,0. No inc_* pulses. Each change occurs 2+4+1 cycles after the press edge.
- MODE bouncing 1,0,1,0 at 2-cycle intervals, then stable high 10 cycles -> exactly one mode step, to 1.
- In SET_MINS, ADJUST held 40 cycles -> inc_mins pulses at press-event+1, then +20, +25, +30, +35. inc_secs and inc_hours stay 0.
- In RUN, ADJUST pressed -> no inc pulses. In SET_HOURS, MODE and ADJUST rising together -> mode=0, no inc_hours.
- Enter SET_SECS, then idle 100 cycles -> mode returns to 0 exactly at the timeout. tick_1hz_in edges during SET_SECS produce no sec_tick; edges after return produce sec_tick 3 cycles later.
- ADJUST held in SET_SECS with reset asserted mid-repeat -> all outputs 0 immediately. After release with ADJUST still high, no pulse until a new debounced press in a SET state.
